// File: rtl/block_memory_ctrl.sv
// block_memory_ctrl: clocked block memory with a request/response handshake.
// One block transfer is outstanding at a time. A request is latched in IDLE,
// the access happens LATENCY edges later, and the response is held in RESP
// until the consumer takes it. Storage is one bank per word slot of a block,
// so a whole block is read or written in a single cycle.
// Word mapping: word 0 of a block sits in the MS bits of wdata/rdata, and
// write-mask bit i enables word i.
module block_memory_ctrl #(
   parameter int WORD_W          = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int ADDR_W          = 10,
   parameter int DEPTH_WORDS     = 256,
   parameter int LATENCY         = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              lock,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_write,
   input  logic [ADDR_W-1:0]                 req_addr,
   input  logic [WORD_W*WORDS_PER_BLOCK-1:0] req_wdata,
   input  logic [WORDS_PER_BLOCK-1:0]        req_wmask,
   output logic                              resp_valid,
   input  logic                              resp_ready,
   output logic [WORD_W*WORDS_PER_BLOCK-1:0] resp_rdata,
   output logic                              resp_err
);
   localparam int BLK_W  = WORD_W * WORDS_PER_BLOCK;
   localparam int OFF_W  = $clog2(BLK_W / 8);
   localparam int BNUM_W = ADDR_W - OFF_W;
   localparam int ROWS   = DEPTH_WORDS / WORDS_PER_BLOCK;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W  = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_write;
   logic [BNUM_W-1:0]       r_blk;
   logic [BLK_W-1:0]        r_wdata;
   logic [WORDS_PER_BLOCK-1:0] r_wmask;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_err;

   logic                    w_accept;
   logic                    w_fire;
   logic                    w_err;
   logic [31:0]             w_blk;
   logic [ROW_W-1:0]        w_row;
   logic [BLK_W-1:0]        w_rdata;
   logic                    w_unused;

   // Block offset bits select bytes inside a block and carry no meaning here.
   assign w_unused = ^req_addr;

   // Block number and range check of the latched request.
   assign w_blk = 32'(r_blk);
   assign w_err = ((w_blk + 32'd1) * 32'(WORDS_PER_BLOCK)) > 32'(DEPTH_WORDS);
   assign w_row = w_blk[ROW_W-1:0];

   // The access edge: last cycle of BUSY.
   assign w_fire   = (r_state == S_BUSY) && (r_cnt == '0);
   assign w_accept = req_valid && req_ready;

   assign resp_valid = (r_state == S_RESP);
   assign resp_err   = r_err;
   assign resp_rdata = w_rdata;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and request-side handshake.
   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = !lock && !rst;
            if (req_valid && !lock && !rst) begin
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) begin
               w_state_next = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Request latch, latency countdown and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write <= 1'b0;
         r_blk   <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_write <= req_write;
            r_blk   <= req_addr[ADDR_W-1:OFF_W];
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            r_cnt   <= CNT_W'(LATENCY - 1);
         end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_fire) begin
            r_err <= w_err;
         end
      end
   end

   // One bank per word slot; row = block number.
   genvar gi;
   generate
      for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_bank
         logic [WORD_W-1:0] r_mem [ROWS];
         logic [WORD_W-1:0] r_word;

         // Masked word commit; out-of-range blocks never reach the array.
         always_ff @(posedge clk) begin
            if (w_fire && r_write && !w_err && r_wmask[gi]) begin
               r_mem[w_row] <= r_wdata[BLK_W-1-gi*WORD_W -: WORD_W];
            end
         end

         // Registered read into the response word; zero for writes and errors.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_word <= '0;
            end else if (w_fire) begin
               r_word <= (r_write || w_err) ? '0 : r_mem[w_row];
            end
         end

         assign w_rdata[BLK_W-1-gi*WORD_W -: WORD_W] = r_word;
      end
   endgenerate

endmodule
